// File: rtl/ctl_trigger_multi.sv
// Per-player light-gun / mouse shot governor: synchronises and debounces gun pins,
// tracks gun presence, and turns each trigger press into one shot plus one hit or miss.
module ctl_trigger_multi #(
    parameter int N_PLAYERS         = 2,
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int HIT_WINDOW_CYCLES = 8,
    parameter int CONNECT_CYCLES    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_PLAYERS-1:0] gun_trigger,
    input  logic [N_PLAYERS-1:0] gun_photodetector,
    input  logic [N_PLAYERS-1:0] mouse_left,
    input  logic [N_PLAYERS-1:0] mouse_on_target,
    output logic [N_PLAYERS-1:0] gun_is_connected,
    output logic [N_PLAYERS-1:0] shot_fired,
    output logic [N_PLAYERS-1:0] hit,
    output logic [N_PLAYERS-1:0] miss
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HWW = $clog2(HIT_WINDOW_CYCLES + 1);
    localparam int CNW = $clog2(CONNECT_CYCLES + 1);

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNW-1:0] CN_LAST  = CNW'(CONNECT_CYCLES - 1);
    localparam logic [HWW-1:0] WIN_LOAD = HWW'(HIT_WINDOW_CYCLES);
    localparam logic [HWW-1:0] WIN_ONE  = HWW'(1);

    typedef enum logic [1:0] {
        IDLE,
        WINDOW,
        RESULT_MOUSE,
        HOLDOFF
    } state_t;

    genvar g;
    for (g = 0; g < N_PLAYERS; g++) begin : ch
        logic           trg_s1, trg_s2, pd_s1, pd_s2;
        logic           trg_db, trg_db_q, mouse_q;
        logic [DBW-1:0] db_cnt;
        logic [CNW-1:0] conn_cnt;
        logic           conn;
        logic           presence;

        state_t         state, state_nx;
        logic           mode, mode_nx;
        logic [HWW-1:0] win_cnt, win_cnt_nx;
        logic           tgt, tgt_nx;
        logic           shot_nx, hit_nx, miss_nx;
        logic           shot_q, hit_q, miss_q;

        assign presence = trg_s2 | pd_s2;

        // Input conditioning: synchronisers, trigger debounce and presence filter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                trg_s1   <= 1'b0;
                trg_s2   <= 1'b0;
                pd_s1    <= 1'b0;
                pd_s2    <= 1'b0;
                trg_db   <= 1'b1;
                trg_db_q <= 1'b1;
                mouse_q  <= 1'b0;
                db_cnt   <= '0;
                conn_cnt <= '0;
                conn     <= 1'b0;
            end else begin
                trg_s1   <= gun_trigger[g];
                trg_s2   <= trg_s1;
                pd_s1    <= gun_photodetector[g];
                pd_s2    <= pd_s1;
                trg_db_q <= trg_db;
                mouse_q  <= mouse_left[g];

                if (trg_s2 != trg_db) begin
                    if (db_cnt >= DB_LAST) begin
                        trg_db <= trg_s2;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + DBW'(1);
                    end
                end else begin
                    db_cnt <= '0;
                end

                if (presence != conn) begin
                    if (conn_cnt >= CN_LAST) begin
                        conn     <= presence;
                        conn_cnt <= '0;
                    end else begin
                        conn_cnt <= conn_cnt + CNW'(1);
                    end
                end else begin
                    conn_cnt <= '0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= IDLE;
                mode    <= 1'b0;
                win_cnt <= '0;
                tgt     <= 1'b0;
                shot_q  <= 1'b0;
                hit_q   <= 1'b0;
                miss_q  <= 1'b0;
            end else begin
                state   <= state_nx;
                mode    <= mode_nx;
                win_cnt <= win_cnt_nx;
                tgt     <= tgt_nx;
                shot_q  <= shot_nx;
                hit_q   <= hit_nx;
                miss_q  <= miss_nx;
            end
        end

        // In IDLE the live connection status picks the mode; it is then frozen for the shot.
        always_comb begin
            state_nx   = state;
            mode_nx    = mode;
            win_cnt_nx = win_cnt;
            tgt_nx     = tgt;
            shot_nx    = 1'b0;
            hit_nx     = 1'b0;
            miss_nx    = 1'b0;
            unique case (state)
                IDLE: begin
                    mode_nx = conn;
                    if (conn) begin
                        if (trg_db_q && !trg_db) begin
                            shot_nx    = 1'b1;
                            win_cnt_nx = WIN_LOAD;
                            state_nx   = WINDOW;
                        end
                    end else if (mouse_left[g] && !mouse_q) begin
                        shot_nx  = 1'b1;
                        tgt_nx   = mouse_on_target[g];
                        state_nx = RESULT_MOUSE;
                    end
                end
                WINDOW: begin
                    if (pd_s2) begin
                        hit_nx   = 1'b1;
                        state_nx = HOLDOFF;
                    end else if (win_cnt <= WIN_ONE) begin
                        win_cnt_nx = '0;
                        miss_nx    = 1'b1;
                        state_nx   = HOLDOFF;
                    end else begin
                        win_cnt_nx = win_cnt - WIN_ONE;
                    end
                end
                RESULT_MOUSE: begin
                    hit_nx   = tgt;
                    miss_nx  = !tgt;
                    state_nx = HOLDOFF;
                end
                HOLDOFF: begin
                    if (mode ? trg_db : !mouse_left[g]) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        assign gun_is_connected[g] = conn;
        assign shot_fired[g]       = shot_q;
        assign hit[g]              = hit_q;
        assign miss[g]             = miss_q;
    end

endmodule

// File: tb/tb_ctl_trigger_multi.sv
// Self-checking bench for ctl_trigger_multi: directed latency scenarios followed by
// randomised per-channel play, all compared cycle by cycle against a behavioural model.
module tb_ctl_trigger_multi;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int HW = 8;
    localparam int CN = 16;
    localparam int W  = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] gun_trigger, gun_photodetector, mouse_left, mouse_on_target;
    logic [N-1:0] gun_is_connected, shot_fired, hit, miss;

    always #5 clk = ~clk;

    ctl_trigger_multi #(
        .N_PLAYERS(N), .DEBOUNCE_CYCLES(DB), .HIT_WINDOW_CYCLES(HW), .CONNECT_CYCLES(CN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .gun_trigger(gun_trigger), .gun_photodetector(gun_photodetector),
        .mouse_left(mouse_left), .mouse_on_target(mouse_on_target),
        .gun_is_connected(gun_is_connected), .shot_fired(shot_fired),
        .hit(hit), .miss(miss)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];

    int t_shot[N], t_hit[N], t_miss[N], t_conn[N];
    int n_shot[N], n_hit[N], n_miss[N];
    bit prev_conn[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural model: pins seen two edges late, run-length filters, shot bookkeeping by flags.
    bit m_t1[N], m_t2[N], m_p1[N], m_p2[N];
    bit m_db[N], m_db_prev[N], m_conn[N], m_ml_prev[N];
    int m_db_run[N], m_conn_run[N], m_win[N];
    bit m_busy_gun[N], m_busy_mouse[N], m_wait[N], m_rel_gun[N], m_tgt[N];
    bit e_shot[N], e_hit[N], e_miss[N];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_t1[i] = 0; m_t2[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
            m_db[i] = 1; m_db_prev[i] = 1; m_conn[i] = 0; m_ml_prev[i] = 0;
            m_db_run[i] = 0; m_conn_run[i] = 0; m_win[i] = 0;
            m_busy_gun[i] = 0; m_busy_mouse[i] = 0; m_wait[i] = 0; m_rel_gun[i] = 0; m_tgt[i] = 0;
            e_shot[i] = 0; e_hit[i] = 0; e_miss[i] = 0;
        end
    endfunction

    function automatic void model_step();
        bit pres;
        for (int i = 0; i < N; i++) begin
            e_shot[i] = 0; e_hit[i] = 0; e_miss[i] = 0;
            if (m_wait[i]) begin
                if (m_rel_gun[i] ? m_db[i] : !mouse_left[i]) m_wait[i] = 0;
            end else if (m_busy_gun[i]) begin
                if (m_p2[i]) begin
                    e_hit[i] = 1; m_busy_gun[i] = 0; m_wait[i] = 1;
                end else begin
                    m_win[i]--;
                    if (m_win[i] == 0) begin
                        e_miss[i] = 1; m_busy_gun[i] = 0; m_wait[i] = 1;
                    end
                end
            end else if (m_busy_mouse[i]) begin
                e_hit[i] = m_tgt[i]; e_miss[i] = !m_tgt[i];
                m_busy_mouse[i] = 0; m_wait[i] = 1;
            end else if (m_conn[i]) begin
                if (m_db_prev[i] && !m_db[i]) begin
                    e_shot[i] = 1; m_busy_gun[i] = 1; m_win[i] = HW; m_rel_gun[i] = 1;
                end
            end else if (mouse_left[i] && !m_ml_prev[i]) begin
                e_shot[i] = 1; m_busy_mouse[i] = 1; m_tgt[i] = mouse_on_target[i]; m_rel_gun[i] = 0;
            end

            m_ml_prev[i] = mouse_left[i];
            m_db_prev[i] = m_db[i];
            if (m_t2[i] != m_db[i]) begin
                m_db_run[i]++;
                if (m_db_run[i] == DB) begin m_db[i] = m_t2[i]; m_db_run[i] = 0; end
            end else m_db_run[i] = 0;
            pres = m_t2[i] | m_p2[i];
            if (pres != m_conn[i]) begin
                m_conn_run[i]++;
                if (m_conn_run[i] == CN) begin m_conn[i] = pres; m_conn_run[i] = 0; end
            end else m_conn_run[i] = 0;
            m_t2[i] = m_t1[i]; m_t1[i] = gun_trigger[i];
            m_p2[i] = m_p1[i]; m_p1[i] = gun_photodetector[i];
        end
    endfunction

    // One clock: model and expectation at the rising edge, DUT compared at the falling edge.
    task automatic tick();
        logic [W-1:0] v;
        @(posedge clk);
        cyc++;
        if (rst_n) model_step();
        else model_reset();
        for (int c = 0; c < N; c++) begin
            v[3*N+c] = m_conn[c]; v[2*N+c] = e_shot[c]; v[N+c] = e_hit[c]; v[c] = e_miss[c];
        end
        exp_q.push_back(v);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 0, 1);
        end else begin
            v = exp_q.pop_front();
            check("connected", gun_is_connected, v[4*N-1 -: N]);
            check("shot_fired", shot_fired, v[3*N-1 -: N]);
            check("hit", hit, v[2*N-1 -: N]);
            check("miss", miss, v[N-1 -: N]);
            check("hit_miss_excl", hit & miss, 0);
        end
        for (int c = 0; c < N; c++) begin
            if (shot_fired[c] === 1'b1) begin t_shot[c] = cyc; n_shot[c]++; end
            if (hit[c] === 1'b1) begin t_hit[c] = cyc; n_hit[c]++; end
            if (miss[c] === 1'b1) begin t_miss[c] = cyc; n_miss[c]++; end
            if (gun_is_connected[c] === 1'b1 && !prev_conn[c]) t_conn[c] = cyc;
            prev_conn[c] = (gun_is_connected[c] === 1'b1);
        end
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {gun_is_connected, shot_fired, hit, miss}, 0);
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, tm, base;
        int kind[N];
        gun_trigger = '0; gun_photodetector = '0; mouse_left = '0; mouse_on_target = '0;
        for (int c = 0; c < N; c++) begin
            t_shot[c] = -1; t_hit[c] = -1; t_miss[c] = -1; t_conn[c] = -1;
            n_shot[c] = 0; n_hit[c] = 0; n_miss[c] = 0; prev_conn[c] = 0;
        end
        model_reset();
        repeat (3) tick();

        // Reset release and ch0 connection: 2 sync + 16 presence cycles.
        rst_n = 1'b1;
        gun_trigger[0] = 1'b1;
        t0 = cyc;
        repeat (24) tick();
        check("conn_latency", t_conn[0] - t0, 18);
        check("conn_ch1_idle", gun_is_connected[1], 0);
        check("no_pulses_at_connect", n_shot[0] + n_shot[1] + n_hit[0] + n_hit[1] + n_miss[0] + n_miss[1], 0);

        // Gun hit: light seen at the pins two cycles after shot_fired.
        base = n_miss[0];
        gun_trigger[0] = 1'b0; t0 = cyc;
        repeat (9) tick();
        gun_photodetector[0] = 1'b1;
        tick();
        gun_trigger[0] = 1'b1;
        repeat (4) tick();
        gun_photodetector[0] = 1'b0;
        repeat (12) tick();
        check("gun_shot_latency", t_shot[0] - t0, 7);
        check("gun_hit_latency", t_hit[0] - t0, 12);
        check("gun_hit_no_miss", n_miss[0] - base, 0);

        // Short glitch must not fire.
        base = n_shot[0] + n_hit[0] + n_miss[0];
        gun_trigger[0] = 1'b0;
        repeat (2) tick();
        gun_trigger[0] = 1'b1;
        repeat (12) tick();
        check("glitch_no_pulses", n_shot[0] + n_hit[0] + n_miss[0] - base, 0);

        // Long hold with no light: one shot, miss after the window, disconnect while held.
        base = n_shot[0];
        gun_trigger[0] = 1'b0; t0 = cyc;
        repeat (20) tick();
        check("miss_shot_latency", t_shot[0] - t0, 7);
        check("miss_after_window", t_miss[0] - t_shot[0], 8);
        check("held_single_shot", n_shot[0] - base, 1);
        check("held_disconnects", gun_is_connected[0], 0);
        gun_trigger[0] = 1'b1;
        repeat (8) tick();
        mouse_on_target[0] = 1'b1; mouse_left[0] = 1'b1; tm = cyc;
        tick();
        mouse_left[0] = 1'b0; mouse_on_target[0] = 1'b0;
        repeat (4) tick();
        check("post_disc_mouse_shot", t_shot[0] - tm, 1);
        check("post_disc_mouse_hit", t_hit[0] - tm, 2);
        repeat (25) tick();
        check("ch0_reconnected", gun_is_connected[0], 1);

        // Mouse mode on ch1: on target then off target.
        for (int k = 0; k < 2; k++) begin
            mouse_on_target[1] = (k == 0); mouse_left[1] = 1'b1; tm = cyc;
            tick();
            mouse_left[1] = 1'b0;
            repeat (4) tick();
            check("mouse_shot_latency", t_shot[1] - tm, 1);
            check(k == 0 ? "mouse_hit_latency" : "mouse_miss_latency",
                  (k == 0 ? t_hit[1] : t_miss[1]) - tm, 2);
        end

        // Simultaneous gun hit on ch0 and mouse miss on ch1.
        base = n_hit[1];
        mouse_on_target[1] = 1'b0;
        gun_trigger[0] = 1'b0; t0 = cyc;
        repeat (6) tick();
        mouse_left[1] = 1'b1;
        tick();
        mouse_left[1] = 1'b0;
        repeat (2) tick();
        gun_photodetector[0] = 1'b1;
        tick();
        gun_trigger[0] = 1'b1;
        repeat (4) tick();
        gun_photodetector[0] = 1'b0;
        repeat (12) tick();
        check("xtalk_ch0_hit", t_hit[0] - t0, 12);
        check("xtalk_ch1_miss", t_miss[1] - t0, 8);
        check("xtalk_ch1_no_hit", n_hit[1] - base, 0);

        // Reset asserted while ch0 is in its hit window drops the shot.
        gun_trigger[0] = 1'b0;
        repeat (9) tick();
        reset_now();
        base = n_hit[0] + n_miss[0];
        repeat (3) tick();
        gun_trigger[0] = 1'b1;
        rst_n = 1'b1;
        repeat (30) tick();
        check("reset_drops_result", n_hit[0] + n_miss[0] - base, 0);

        // Randomised play: each channel alternates between noisy, unplugged and gun-style segments.
        for (int seg = 0; seg < 40; seg++) begin
            for (int c = 0; c < N; c++) kind[c] = $urandom_range(0, 2);
            if (seg == 20) begin
                reset_now();
                repeat (2) tick();
                rst_n = 1'b1;
            end
            repeat (64) begin
                for (int c = 0; c < N; c++) begin
                    case (kind[c])
                        0: begin
                            if ($urandom_range(0, 7) == 0) gun_trigger[c] = ~gun_trigger[c];
                            if ($urandom_range(0, 9) == 0) gun_photodetector[c] = ~gun_photodetector[c];
                        end
                        1: begin
                            gun_trigger[c] = 1'b0;
                            gun_photodetector[c] = 1'b0;
                        end
                        default: begin
                            if (gun_trigger[c] ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 7) == 0))
                                gun_trigger[c] = ~gun_trigger[c];
                            if ($urandom_range(0, 5) == 0) gun_photodetector[c] = ~gun_photodetector[c];
                        end
                    endcase
                    if ($urandom_range(0, 5) == 0) mouse_left[c] = ~mouse_left[c];
                    mouse_on_target[c] = 1'($urandom_range(0, 1));
                end
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
